// File: rtl/fpaddsub_pkg.sv
// Shared constants and encodings for the FPAddSub scheduler.
package fpaddsub_pkg;

    localparam int LAT_DEFAULT = 7;
    localparam int DATA_W      = 32;
    localparam int FLAGS_W     = 5;
    localparam int CTRL_W      = 3;

    // Ctrl field positions: bit 0 selects add/sub, bits 2:1 the rounding mode.
    localparam int CTRL_OP_BIT = 0;
    localparam int CTRL_RM_LSB = 1;
    localparam int CTRL_RM_MSB = 2;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RUP = 2'b01,
        RM_RZ  = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Pack a rounding mode and an operation into a Ctrl word.
    function automatic logic [CTRL_W-1:0] make_ctrl(input rmode_e rm, input op_e op);
        return {rm, op};
    endfunction

endpackage

// File: rtl/fpaddsub_sched_fifo.sv
// Show-ahead synchronous FIFO that holds completed results until the consumer takes them.
module fpaddsub_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    // Head is forced to zero when empty so the outputs read 0 out of reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage write.
    // NOTE: the storage array is deliberately not reset; validity is tracked by
    // the pointers and count, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpaddsub_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined FPAddSub among NREQ requesters.
module fpaddsub_sched
    import fpaddsub_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
    output logic [DATA_W-1:0]        fpu_a,
    output logic [DATA_W-1:0]        fpu_b,
    output logic [CTRL_W-1:0]        fpu_ctrl,
    input  logic [DATA_W-1:0]        fpu_z,
    input  logic [FLAGS_W-1:0]       fpu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [DATA_W-1:0]        rsp_z,
    output logic [FLAGS_W-1:0]       rsp_flags,
    output logic                     busy
);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int ENTRY_W = IDW + DATA_W + FLAGS_W;

    logic [IDW-1:0]     r_ptr;
    logic [CW-1:0]      r_count;
    logic [LAT-1:0]     r_tag_vld;
    logic [IDW-1:0]     r_tag_id [LAT];

    logic [IDW-1:0]     w_grant;
    logic               w_any;
    logic               w_pop;
    logic               w_issue;
    logic               w_empty;
    logic               w_full;
    logic [ENTRY_W-1:0] w_head;

    assign w_pop     = rsp_valid && rsp_ready;
    // A pop in the same cycle frees the credit the new issue consumes.
    // Issue is also held off while reset is asserted so req_ready reads 0.
    assign w_issue   = rst && w_any && ((r_count != CW'(DEPTH)) || w_pop);
    assign busy      = (r_count != '0);
    assign rsp_valid = !w_empty;
    assign {rsp_id, rsp_z, rsp_flags} = w_head;

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        int v_idx;
        w_any   = 1'b0;
        w_grant = '0;
        v_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            if (req_valid[v_idx]) begin
                w_any   = 1'b1;
                w_grant = IDW'(v_idx);
            end
        end
    end

    // Grant strobe and FPU operand mux; all zero on idle cycles.
    always_comb begin
        req_ready = '0;
        fpu_a     = '0;
        fpu_b     = '0;
        fpu_ctrl  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_issue && (w_grant == IDW'(i));
        end
        if (w_issue) begin
            fpu_a    = req_a[w_grant*DATA_W +: DATA_W];
            fpu_b    = req_b[w_grant*DATA_W +: DATA_W];
            fpu_ctrl = req_ctrl[w_grant*CTRL_W +: CTRL_W];
        end
    end

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
        end
    end

    // Tag pipe mirrors the FPU latency; the last stage lines up with fpu_z.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_grant;
            for (int k = 1; k < LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    // Credit count: operations issued but not yet handed to the consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fpaddsub_sched_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_tag_vld[LAT-1]),
        .i_data  ({r_tag_id[LAT-1], fpu_z, fpu_flags}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // The credit scheme must keep the FIFO from ever overflowing.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        r_tag_vld[LAT-1] |-> !w_full);
    a_count_bounded: assert property (@(posedge clk) disable iff (!rst)
        r_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fpaddsub_sched.sv
// Directed self-checking bench for fpaddsub_sched with a behavioural LAT-stage FPU.
module tb_fpaddsub_sched;
  import fpaddsub_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = 7;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*32-1:0]     req_a;
  logic [NREQ*32-1:0]     req_b;
  logic [NREQ*3-1:0]      req_ctrl;
  logic [31:0]            fpu_a;
  logic [31:0]            fpu_b;
  logic [2:0]             fpu_ctrl;
  logic [31:0]            fpu_z;
  logic [4:0]             fpu_flags;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [31:0]            rsp_z;
  logic [4:0]             rsp_flags;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpaddsub_sched #(
    .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl),
    .fpu_z(fpu_z), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Behavioural FPAddSub: known IEEE vectors from a table, otherwise a
  // distinctive operand mix so every slot's result is traceable.
  function automatic logic [36:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 3'b000) return {5'b00000, 32'h4040_0000};
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 && c == 3'b001) return {5'b00000, 32'h4000_0000};
    if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF && c == 3'b000) return {5'b10001, 32'h7F80_0000};
    return {a[4:0], a ^ b ^ {29'b0, c}};
  endfunction

  logic [36:0] m_pipe [LAT];
  always @(posedge clk) begin
    m_pipe[0] <= fpu_model(fpu_a, fpu_b, fpu_ctrl);
    for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
  end
  assign {fpu_flags, fpu_z} = m_pipe[LAT-1];

  // Streaming operand pattern: requester i, sequence s.
  function automatic logic [31:0] st_a(input int i, input int s);
    return {8'hA0 + 8'(i), 8'h00, 16'(s)};
  endfunction
  function automatic logic [31:0] st_b(input int i);
    return {8'h00, 8'(i), 16'h5A5A};
  endfunction
  function automatic logic [2:0] st_c(input int i);
    return 3'(i);
  endfunction
  function automatic logic [31:0] st_z(input int i, input int s);
    return st_a(i, s) ^ st_b(i) ^ {29'b0, st_c(i)};
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_ctrl[i*3 +: 3] = c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, st_a(i, 0), st_b(i), st_c(i));
    #12;
    check(req_ready === '0 && rsp_valid === 1'b0 && busy === 1'b0,
          $sformatf("reset_ctrl: ready=%b rsp_valid=%b busy=%b expected 0000/0/0",
                    req_ready, rsp_valid, busy));
    check(rsp_id === '0 && rsp_z === '0 && rsp_flags === '0,
          $sformatf("reset_rsp: id=%0d z=%h flags=%b expected 0/0/0", rsp_id, rsp_z, rsp_flags));
    check(fpu_a === '0 && fpu_b === '0 && fpu_ctrl === '0,
          $sformatf("reset_fpu: a=%h b=%h ctrl=%b expected all 0", fpu_a, fpu_b, fpu_ctrl));
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
  endtask

  // One operation from requester idx, checked for latency and result.
  task automatic run_single(input string name, input int idx, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] c,
                            input logic [31:0] ez, input logic [4:0] ef, input logic [4:0] fmask);
    int  lat;
    bit  got;
    @(posedge clk); #1;
    set_req(idx, a, b, c);
    req_valid = NREQ'(1 << idx);
    rsp_ready = 1'b1;
    @(negedge clk);
    check(req_ready === NREQ'(1 << idx) && fpu_a === a && fpu_b === b && fpu_ctrl === c,
          $sformatf("%s_issue: ready=%b a=%h b=%h c=%b expected %b %h %h %b",
                    name, req_ready, fpu_a, fpu_b, fpu_ctrl, NREQ'(1 << idx), a, b, c));
    @(posedge clk); #1;
    req_valid = '0;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = n;
      end
    end
    check(lat == LAT + 1,
          $sformatf("%s_latency: got %0d cycles expected %0d", name, lat, LAT + 1));
    check(rsp_id === IDW'(idx) && rsp_z === ez && (rsp_flags & fmask) === (ef & fmask),
          $sformatf("%s_result: id=%0d z=%h flags=%b expected %0d %h %b (mask %b)",
                    name, rsp_id, rsp_z, rsp_flags, idx, ez, ef, fmask));
    @(negedge clk);
    check(rsp_valid === 1'b0 && busy === 1'b0,
          $sformatf("%s_drain: rsp_valid=%b busy=%b expected 0/0", name, rsp_valid, busy));
  endtask

  task automatic test_single();
    run_single("single", 0, 32'h3F80_0000, 32'h4000_0000, make_ctrl(RM_RNE, OP_ADD),
               32'h4040_0000, 5'b00000, 5'b11111);
  endtask

  task automatic test_subtract();
    run_single("subtract", 2, 32'h4040_0000, 32'h3F80_0000, make_ctrl(RM_RNE, OP_SUB),
               32'h4000_0000, 5'b00000, 5'b11111);
  endtask

  task automatic test_overflow();
    run_single("overflow", 3, 32'h7F7F_FFFF, 32'h7F7F_FFFF, make_ctrl(RM_RNE, OP_ADD),
               32'h7F80_0000, 5'b10000, 5'b10000);
  endtask

  // All requesters valid, consumer always ready: 16 back-to-back issues.
  task automatic test_back_to_back();
    int seq [NREQ];
    int acc;
    int pops;
    logic [NREQ-1:0] seen;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      set_req(i, st_a(i, 0), st_b(i), st_c(i));
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    acc = 0;
    pops = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc < 16) begin
        check(req_ready === NREQ'(1 << (cyc % NREQ)),
              $sformatf("rr_grant[%0d]: got %b expected %b", cyc, req_ready,
                        NREQ'(1 << (cyc % NREQ))));
      end
      if (cyc >= LAT + 1 && cyc < LAT + 1 + 16) begin
        int k;
        k = cyc - (LAT + 1);
        check(rsp_valid === 1'b1 && rsp_id === IDW'(k % NREQ) && rsp_z === st_z(k % NREQ, k / NREQ),
              $sformatf("rr_rsp[%0d]: valid=%b id=%0d z=%h expected 1 %0d %h", k,
                        rsp_valid, rsp_id, rsp_z, k % NREQ, st_z(k % NREQ, k / NREQ)));
      end
      if (rsp_valid) pops++;
      seen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (seen[i]) begin
          acc++;
          seq[i]++;
          set_req(i, st_a(i, seq[i]), st_b(i), st_c(i));
        end
      end
      if (acc >= 16) req_valid = '0;
    end
    check(pops == 16 && busy === 1'b0,
          $sformatf("rr_total: pops=%0d busy=%b expected 16/0", pops, busy));
  endtask

  // Consumer stalled: exactly DEPTH issues, then resume on the first pop.
  task automatic test_backpressure();
    int seq [NREQ];
    int pops;
    logic [NREQ-1:0] seen;
    logic [NREQ-1:0] exp_rdy;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      set_req(i, st_a(i, 0), st_b(i), st_c(i));
    end
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      exp_rdy = (cyc < DEPTH) ? NREQ'(1 << (cyc % NREQ)) : NREQ'(0);
      check(req_ready === exp_rdy,
            $sformatf("bp_grant[%0d]: got %b expected %b", cyc, req_ready, exp_rdy));
      if (cyc == 19) begin
        check(rsp_valid === 1'b1 && busy === 1'b1 && rsp_id === '0,
              $sformatf("bp_full: rsp_valid=%b busy=%b id=%0d expected 1/1/0",
                        rsp_valid, busy, rsp_id));
      end
      seen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (seen[i]) begin
          seq[i]++;
          set_req(i, st_a(i, seq[i]), st_b(i), st_c(i));
        end
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check(rsp_valid === 1'b1 && req_ready === NREQ'(1),
          $sformatf("bp_resume: rsp_valid=%b ready=%b expected 1/%b", rsp_valid, req_ready, NREQ'(1)));
    pops = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (rsp_valid) begin
        check(rsp_id === IDW'(pops % NREQ) && rsp_z === st_z(pops % NREQ, pops / NREQ),
              $sformatf("bp_rsp[%0d]: id=%0d z=%h expected %0d %h", pops, rsp_id, rsp_z,
                        pops % NREQ, st_z(pops % NREQ, pops / NREQ)));
        pops++;
      end
      @(posedge clk); #1;
      req_valid = '0;
    end
    check(pops == DEPTH + 1 && busy === 1'b0,
          $sformatf("bp_total: pops=%0d busy=%b expected %0d/0", pops, busy, DEPTH + 1));
  endtask

  // Reset with five operations in flight discards them all.
  task automatic test_reset_mid();
    int accepted;
    bit stray;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, st_a(i, 7), st_b(i), st_c(i));
    rsp_ready = 1'b1;
    req_valid = '1;
    accepted = 0;
    for (int cyc = 0; cyc < 20 && accepted < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) accepted++;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check(accepted == 5 && req_ready === '0 && rsp_valid === 1'b0 && busy === 1'b0,
          $sformatf("midrst_ctrl: accepted=%0d ready=%b rsp_valid=%b busy=%b expected 5/0000/0/0",
                    accepted, req_ready, rsp_valid, busy));
    check(fpu_a === '0 && fpu_b === '0 && fpu_ctrl === '0 && rsp_z === '0 && rsp_id === '0 &&
          rsp_flags === '0,
          $sformatf("midrst_data: fpu_a=%h fpu_b=%h ctrl=%b z=%h id=%0d flags=%b expected all 0",
                    fpu_a, fpu_b, fpu_ctrl, rsp_z, rsp_id, rsp_flags));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    stray = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    check(!stray, $sformatf("midrst_quiet: stray response or credit seen=%b expected 0", stray));
  endtask

  // Pointer returns to requester 0 after reset.
  task automatic test_after_reset();
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check(req_ready === NREQ'(1),
          $sformatf("postrst_grant: got %b expected %b", req_ready, NREQ'(1)));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LAT + 4) @(posedge clk);
  endtask

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpaddsub_sched.md
# fpaddsub_sched

Round-robin scheduler that shares one pipelined FPAddSub unit among NREQ requesters. Each requester offers operands with a valid/ready handshake. The scheduler issues at most one operation per cycle into the fixed-latency, non-stallable adder pipeline and tags each issued slot with the requester ID. It returns results, in issue order, through a single response port with backpressure. Issue is gated by a credit count, so no result can be lost while the response port is stalled.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- LAT, 7, FPAddSub latency in cycles, from operand presentation to Z/Flags valid
- DEPTH, 8, maximum outstanding operations (credits) and result FIFO depth; must be ≥ LAT+1

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1, clock.
  - rst, in, 1, reset; asynchronous and active-low (0 = reset asserted).
- req_valid, in, NREQ, requester i offers an operation.
- req_ready, out, NREQ, one-hot grant to requester i; the operation is accepted this cycle.
- req_a, in, NREQ*32, operand A per requester (slice i = bits 32i+31:32i).
- req_b, in, NREQ*32, operand B per requester.
- req_ctrl, in, NREQ*3, Ctrl per requester: bits 2:1 rounding mode, bit 0 add/sub.
- fpu_a, out, 32, drives FPAddSub A.
- fpu_b, out, 32, drives FPAddSub B.
- fpu_ctrl, out, 3, drives FPAddSub Ctrl.
- fpu_z, in, 32, FPAddSub Z.
- fpu_flags, in, 5, FPAddSub Flags.
- rsp_valid, out, 1, the response head is valid.
- rsp_ready, in, 1, the consumer accepts the response.
- rsp_id, out, IDW, requester that owns the head result.
- rsp_z, out, 32, result.
- rsp_flags, out, 5, flags (overflow, underflow, div0, invalid, inexact).
- busy, out, 1, credit count is non-zero.

## Operation
- Arbitration:
  - Round-robin pointer `ptr`, reset to 0.
  - The grant goes to the first i with req_valid[i], searching from ptr upward and wrapping.
  - req_ready is asserted only for the granted i, and only when issue is permitted. It may depend combinationally on req_valid.
  - On issue, ptr <= grant+1, wrapping at NREQ.
- Issue permitted when either condition holds:
  - count < DEPTH, or
  - count == DEPTH and a response pop (rsp_valid && rsp_ready) occurs in the same cycle.
- FPU drive:
  - fpu_a, fpu_b and fpu_ctrl are muxed combinationally from the granted requester.
  - All three are zero when nothing issues. The FPU samples every cycle; idle slots become bubbles.
- Tag pipe:
  - LAT-stage shift register of {valid, id}.
  - Stage 1 loads {issue, grant} every cycle.
  - Stage LAT is aligned with fpu_z/fpu_flags.
- Capture: when stage LAT is valid, push {id, fpu_z, fpu_flags} into the result FIFO at that edge.
- Result FIFO:
  - Show-ahead, DEPTH entries.
  - rsp_valid = !empty; rsp_id, rsp_z and rsp_flags come from the head.
  - The head pops on rsp_valid && rsp_ready.
- Credit count:
  - count = operations issued but not yet popped, width clog2(DEPTH+1).
  - Increments on issue, decrements on pop, and is unchanged when both occur in the same cycle.
- Overflow rule: count ≤ DEPTH guarantees that a FIFO push never finds the FIFO full. Verification asserts this.
- FPAddSub's own synchronous reset is tied inactive by the integrator. Correctness never depends on FPU contents outside tagged slots.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, busy = 0.
  - rsp_id, rsp_z, rsp_flags = 0.
  - fpu_a, fpu_b, fpu_ctrl = 0.
  - ptr = 0, count = 0, all tag stages invalid, FIFO empty.
- Issue in cycle c0 produces fpu_z valid in c0+LAT and rsp_valid in c0+LAT+1 (8 cycles at default parameters).
- Sustained throughput: one issue per cycle when rsp_ready is held at 1 and DEPTH ≥ LAT+1.
- Backpressure: with rsp_ready = 0, exactly DEPTH issues are accepted, then req_ready stays 0 until a pop. Issue resumes in the same cycle as the first pop.
- Ordering: responses leave in issue order, regardless of requester.
- Reset asserted mid-operation:
  - All in-flight and buffered results are discarded and no rsp_valid follows.
  - Stale FPU outputs after release are ignored because the tag stages are invalid.
- A requester holds its valid, operands and ctrl stable until it sees req_ready.

## Structure
- Package `fpaddsub_pkg`:
  - LAT default (7) and FLAGS_W = 5.
  - Ctrl field positions and rounding-mode encodings: RNE = 00, RUP = 01, RZ = 10, RDN = 11.
  - Operation encodings: ADD = 0, SUB = 1.
- Sub-module `fpaddsub_sched_fifo`: a parameterised show-ahead synchronous FIFO with the same async active-low reset. The tag pipe and arbiter stay in the top.

## Test plan
- Single issue: requester 0 sends A = 0x3F800000, B = 0x40000000, ctrl = 000 in c0 → rsp_valid in c8 with rsp_id = 0, rsp_z = 0x40400000, rsp_flags = 0.
- Subtraction: requester 2 sends 0x40400000 − 0x3F800000 with ctrl = 001 → rsp_id = 2, rsp_z = 0x40000000.
- All four requesters valid continuously with rsp_ready = 1 → grants in order 0,1,2,3,0,… and one response per cycle from c8 onward, IDs in the same order.
- rsp_ready = 0 with all requesters valid → exactly 8 accepts, then req_ready = 0. Raise rsp_ready → an accept occurs in the same cycle as the first pop, and no result is lost or duplicated.
- Overflow case: 0x7F7FFFFF + 0x7F7FFFFF, ctrl = 000 → rsp_z = 0x7F800000, rsp_flags[4] = 1.
- Assert rst with 5 operations in flight → outputs are at reset values immediately. After release, no rsp_valid appears for 20 cycles without new requests.
